// File: rtl/sha256_msg_feeder_if.sv
// Signal bundle between the message source, the feeder and the SHA-256
// message-schedule / compression side.
interface sha256_msg_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_bytes;
    logic        core_ready;
    logic        clear_o;
    logic        dat_vaild_o;
    logic [31:0] dat_msb_o;
    logic        proc_ninit_o;
    logic        chunk_done;
    logic        msg_done;

    // Source / schedule side: drives the word stream and core pacing.
    modport master (
        output s_valid, s_data, s_last, s_bytes, core_ready,
        input  s_ready, clear_o, dat_vaild_o, dat_msb_o, proc_ninit_o,
               chunk_done, msg_done
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_data, s_last, s_bytes, core_ready,
        output s_ready, clear_o, dat_vaild_o, dat_msb_o, proc_ninit_o,
               chunk_done, msg_done
    );
endinterface

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: takes a big-endian 32-bit word stream, appends the
// 0x80 marker, zero fill and 64-bit bit length, and emits 512-bit chunks as
// 16 sequential words followed by a fixed-length schedule expansion window.
module sha256_msg_feeder #(
    parameter int LEN_W      = 64,
    parameter int EXP_CYCLES = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    sha256_msg_feeder_if.slave bus
);
    localparam int EXP_W = $clog2(EXP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        DATA   = 3'd2,
        PAD    = 3'd3,
        EXPAND = 3'd4,
        WAIT   = 3'd5
    } state_t;

    state_t           state_r;
    logic [3:0]       idx_r;        // word index within the current chunk
    logic [LEN_W-1:0] bit_cnt_r;    // message length in bits, wraps
    logic [EXP_W-1:0] exp_cnt_r;
    logic             pad_mode_r;   // input finished, remaining words are padding
    logic             pend_80_r;    // 0x80000000 word still owed
    logic             len_here_r;   // current chunk carries the length words
    logic             final_r;      // chunk in flight is the last of the message
    logic             s_ready_r;
    logic             clear_r;
    logic             dat_vld_r;
    logic [31:0]      dat_r;
    logic             proc_r;
    logic             chunk_done_r;
    logic             msg_done_r;

    logic             accept_s;
    logic [LEN_W-1:0] add_bits_s;
    logic [63:0]      len64_s;
    logic [31:0]      pad_word_s;

    // Keep the valid leading bytes of a partial final word, place 0x80 in the
    // first unused byte and clear the rest; a full word passes unchanged.
    function automatic logic [31:0] close_word(input logic [31:0] data,
                                               input logic [1:0]  nbytes);
        logic [31:0] w;
        case (nbytes)
            2'd1:    w = {data[31:24], 8'h80, 16'h0000};
            2'd2:    w = {data[31:16], 8'h80, 8'h00};
            2'd3:    w = {data[31:8], 8'h80};
            default: w = data;
        endcase
        return w;
    endfunction

    // Word acceptance, bit-count increment and the next padding word.
    always_comb begin
        accept_s   = 1'b0;
        add_bits_s = LEN_W'(6'd32);
        len64_s    = 64'(bit_cnt_r);
        pad_word_s = 32'h0000_0000;
        if (state_r == DATA) begin
            accept_s = bus.s_valid & s_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if (bus.s_last && (bus.s_bytes != 2'd0)) begin
            add_bits_s = LEN_W'({bus.s_bytes, 3'b000});
        end else begin
            add_bits_s = LEN_W'(6'd32);
        end
        if (pend_80_r) begin
            pad_word_s = 32'h8000_0000;
        end else if (len_here_r && (idx_r == 4'd14)) begin
            pad_word_s = len64_s[63:32];
        end else if (len_here_r && (idx_r == 4'd15)) begin
            pad_word_s = len64_s[31:0];
        end else begin
            pad_word_s = 32'h0000_0000;
        end
    end

    // Chunk sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= 4'd0;
            bit_cnt_r    <= '0;
            exp_cnt_r    <= '0;
            pad_mode_r   <= 1'b0;
            pend_80_r    <= 1'b0;
            len_here_r   <= 1'b0;
            final_r      <= 1'b0;
            s_ready_r    <= 1'b0;
            clear_r      <= 1'b0;
            dat_vld_r    <= 1'b0;
            dat_r        <= 32'h0000_0000;
            proc_r       <= 1'b0;
            chunk_done_r <= 1'b0;
            msg_done_r   <= 1'b0;
        end else begin
            clear_r      <= 1'b0;
            dat_vld_r    <= 1'b0;
            proc_r       <= 1'b0;
            chunk_done_r <= 1'b0;
            msg_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    s_ready_r <= 1'b0;
                    if (bus.s_valid && bus.core_ready) begin
                        state_r <= CLR;
                        clear_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CLR: begin
                    bit_cnt_r  <= '0;
                    idx_r      <= 4'd0;
                    pad_mode_r <= 1'b0;
                    pend_80_r  <= 1'b0;
                    len_here_r <= 1'b0;
                    final_r    <= 1'b0;
                    s_ready_r  <= 1'b1;
                    state_r    <= DATA;
                end
                DATA: begin
                    if (accept_s) begin
                        dat_vld_r <= 1'b1;
                        idx_r     <= idx_r + 4'd1;
                        bit_cnt_r <= bit_cnt_r + add_bits_s;
                        if (bus.s_last) begin
                            dat_r      <= close_word(bus.s_data, bus.s_bytes);
                            pad_mode_r <= 1'b1;
                            s_ready_r  <= 1'b0;
                            if (bus.s_bytes == 2'd0) begin
                                pend_80_r  <= 1'b1;
                                len_here_r <= 1'b0;
                            end else begin
                                // Marker at index 14 leaves no room for the
                                // length in this chunk; at 15 the next chunk
                                // is pure zeros plus length.
                                pend_80_r  <= 1'b0;
                                len_here_r <= (idx_r != 4'd14);
                            end
                        end else begin
                            dat_r <= bus.s_data;
                            if (idx_r == 4'd15) begin
                                s_ready_r <= 1'b0;
                            end else begin
                                s_ready_r <= 1'b1;
                            end
                        end
                        if (idx_r == 4'd15) begin
                            state_r   <= EXPAND;
                            exp_cnt_r <= '0;
                            final_r   <= 1'b0;
                        end else if (bus.s_last) begin
                            state_r <= PAD;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PAD: begin
                    dat_vld_r <= 1'b1;
                    dat_r     <= pad_word_s;
                    idx_r     <= idx_r + 4'd1;
                    if (pend_80_r) begin
                        pend_80_r  <= 1'b0;
                        len_here_r <= (idx_r <= 4'd13);
                    end else begin
                        pend_80_r <= 1'b0;
                    end
                    if (idx_r == 4'd15) begin
                        state_r   <= EXPAND;
                        exp_cnt_r <= '0;
                        final_r   <= len_here_r;
                        if (!len_here_r) begin
                            len_here_r <= 1'b1;
                        end
                    end else begin
                        state_r <= PAD;
                    end
                end
                EXPAND: begin
                    proc_r <= 1'b1;
                    if (exp_cnt_r == EXP_W'(EXP_CYCLES - 1)) begin
                        chunk_done_r <= 1'b1;
                        msg_done_r   <= final_r;
                        if (final_r) begin
                            state_r    <= IDLE;
                            pad_mode_r <= 1'b0;
                            len_here_r <= 1'b0;
                            final_r    <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        exp_cnt_r <= exp_cnt_r + EXP_W'(1);
                    end
                end
                WAIT: begin
                    idx_r <= 4'd0;
                    if (bus.core_ready) begin
                        if (pad_mode_r) begin
                            state_r <= PAD;
                        end else begin
                            state_r   <= DATA;
                            s_ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    s_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready      = s_ready_r;
    assign bus.clear_o      = clear_r;
    assign bus.dat_vaild_o  = dat_vld_r;
    assign bus.dat_msb_o    = dat_r;
    assign bus.proc_ninit_o = proc_r;
    assign bus.chunk_done   = chunk_done_r;
    assign bus.msg_done     = msg_done_r;

endmodule
